// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised sequence detector: state-width helper,
// elaboration-time failure/transition tables and the default pattern.
package seqdet_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int ENT_W     = 5;
  localparam int FAIL_W    = (MAX_PAT_W + 1) * ENT_W;
  localparam int TRANS_W   = 2 * MAX_PAT_W * ENT_W;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

  function automatic int state_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

  // Bit j of the pattern in arrival order (j = 0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                   input int j);
    return pat[pat_w-1-j];
  endfunction

  // Entry i = length of the longest proper border of the i-bit prefix, i = 0..pat_w.
  function automatic logic [FAIL_W-1:0] fail_table(input logic [MAX_PAT_W-1:0] pat,
                                                   input int pat_w);
    logic [FAIL_W-1:0] tbl;
    int k;
    tbl = '0;
    for (int i = 2; i <= pat_w; i++) begin
      k = int'(tbl[(i-1)*ENT_W +: ENT_W]);
      while (k > 0 && pat_bit(pat, pat_w, k) != pat_bit(pat, pat_w, i-1))
        k = int'(tbl[k*ENT_W +: ENT_W]);
      if (pat_bit(pat, pat_w, k) == pat_bit(pat, pat_w, i-1))
        k++;
      tbl[i*ENT_W +: ENT_W] = ENT_W'(k);
    end
    return tbl;
  endfunction

  // Entry (2*s + b) = next matched-prefix length after accepting bit b in state s.
  function automatic logic [TRANS_W-1:0] trans_table(input logic [MAX_PAT_W-1:0] pat,
                                                     input int pat_w, input bit overlap);
    logic [FAIL_W-1:0]  fail;
    logic [TRANS_W-1:0] tbl;
    int   k;
    logic b;
    fail = fail_table(pat, pat_w);
    tbl  = '0;
    for (int s = 0; s < pat_w; s++) begin
      for (int bi = 0; bi < 2; bi++) begin
        b = bi[0];
        if (pat_bit(pat, pat_w, s) == b) begin
          if (s < pat_w - 1) k = s + 1;
          else               k = overlap ? int'(fail[pat_w*ENT_W +: ENT_W]) : 0;
        end else begin
          k = int'(fail[s*ENT_W +: ENT_W]);
          while (k > 0 && pat_bit(pat, pat_w, k) != b)
            k = int'(fail[k*ENT_W +: ENT_W]);
          k = (pat_bit(pat, pat_w, k) == b) ? k + 1 : 0;
        end
        tbl[(2*s+bi)*ENT_W +: ENT_W] = ENT_W'(k);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seqdet_sat_counter
  import seqdet_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    count_q <= '0;
    else if (clr)                  count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial sequence detector with overlap control and input qualifier.
// Define SEQDET_COUNT_EN to add the saturating match counter and its match_cnt port.
module seq_detect_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      x_in,
  input  logic                      x_valid,
  input  logic                      clear,
  output logic                      y_out,
  output logic [state_w(PAT_W)-1:0] state_o
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]          match_cnt
`endif
);

  localparam int SW = state_w(PAT_W);
  localparam logic [TRANS_W-1:0] TRANS = trans_table(MAX_PAT_W'(PATTERN), PAT_W, OVERLAP);

  if (PAT_W < 2 || PAT_W > MAX_PAT_W || CNT_W < 1) begin : g_bad_params
    $error("seq_detect_param: illegal PAT_W=%0d or CNT_W=%0d", PAT_W, CNT_W);
  end

  logic [SW-1:0] state_q, state_d;

  assign y_out   = x_valid & ~clear & (state_q == SW'(PAT_W-1)) & (x_in == PATTERN[0]);
  assign state_o = state_q;

  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (clear)        state_d = '0;
    else if (x_valid) state_d = SW'(TRANS[int'({state_q, x_in})*ENT_W +: ENT_W]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

`ifdef SEQDET_COUNT_EN
  seqdet_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (y_out),
    .clr   (clear),
    .count (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: 1101 overlap/non-overlap and 11 with a 2-bit counter.
module tb_seq_detect_param;

  logic clock = 1'b0;
  logic reset, x_in, x_valid, clear;
  logic y_ov, y_nov, y_11;
  logic [1:0] st_ov, st_nov;
  logic [0:0] st_11;
`ifdef SEQDET_COUNT_EN
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_11;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .y_out(y_ov), .state_o(st_ov)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_ov)
`endif
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .y_out(y_nov), .state_o(st_nov)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_nov)
`endif
  );

  seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_11 (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .y_out(y_11), .state_o(st_11)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_11)
`endif
  );

  // Drive one cycle of inputs at the falling edge and let combinational outputs settle.
  task automatic apply(input logic b, input logic v, input logic c);
    @(negedge clock);
    x_in = b; x_valid = v; clear = c;
    #1;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_all();
    apply(1'b0, 1'b0, 1'b1);
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b0; x_in = 1'b1; x_valid = 1'b1; clear = 1'b0;
    #1;
    checks++;
    if (st_ov !== 2'd0 || st_nov !== 2'd0 || st_11 !== 1'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d/%0d want 0/0/0", st_ov, st_nov, st_11);
    end
    checks++;
    if (y_ov !== 1'b0 || y_nov !== 1'b0 || y_11 !== 1'b0) begin
      errors++;
      $display("FAIL reset_y: got %b%b%b want 000", y_ov, y_nov, y_11);
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_ov !== 8'd0 || cnt_nov !== 8'd0 || cnt_11 !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cnt_ov, cnt_nov, cnt_11);
    end
`endif
    repeat (2) @(negedge clock);
    x_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic bits   [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic ey_ov  [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic ey_nov [7] = '{0, 0, 0, 1, 0, 0, 0};
    int   es_ov  [7] = '{1, 2, 3, 1, 2, 3, 1};
    int   es_nov [7] = '{1, 2, 3, 0, 1, 0, 1};
    clr_all();
    for (int i = 0; i < 7; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      checks++;
      if (y_ov !== ey_ov[i]) begin
        errors++;
        $display("FAIL overlap_y bit%0d: got %b want %b", i+1, y_ov, ey_ov[i]);
      end
      checks++;
      if (y_nov !== ey_nov[i]) begin
        errors++;
        $display("FAIL nonoverlap_y bit%0d: got %b want %b", i+1, y_nov, ey_nov[i]);
      end
      settle();
      checks++;
      if (int'(st_ov) != es_ov[i]) begin
        errors++;
        $display("FAIL overlap_state bit%0d: got %0d want %0d", i+1, st_ov, es_ov[i]);
      end
      checks++;
      if (int'(st_nov) != es_nov[i]) begin
        errors++;
        $display("FAIL nonoverlap_state bit%0d: got %0d want %0d", i+1, st_nov, es_nov[i]);
      end
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_ov !== 8'd2 || cnt_nov !== 8'd1) begin
      errors++;
      $display("FAIL overlap_cnt: got %0d/%0d want 2/1", cnt_ov, cnt_nov);
    end
`endif
  endtask

  task automatic test_fallback();
    logic bits [5] = '{1, 1, 1, 0, 1};
    logic ey   [5] = '{0, 0, 0, 0, 1};
    int   es   [5] = '{1, 2, 2, 3, 1};
    clr_all();
    for (int i = 0; i < 5; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      checks++;
      if (y_ov !== ey[i]) begin
        errors++;
        $display("FAIL fallback_y bit%0d: got %b want %b", i+1, y_ov, ey[i]);
      end
      settle();
      checks++;
      if (int'(st_ov) != es[i]) begin
        errors++;
        $display("FAIL fallback_state bit%0d: got %0d want %0d", i+1, st_ov, es[i]);
      end
    end
  endtask

  task automatic test_valid_gap();
    logic bits [3] = '{1, 1, 0};
    logic tog  [3] = '{1, 0, 1};
    clr_all();
    for (int i = 0; i < 3; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      settle();
    end
    for (int i = 0; i < 3; i++) begin
      apply(tog[i], 1'b0, 1'b0);
      checks++;
      if (y_ov !== 1'b0 || y_nov !== 1'b0) begin
        errors++;
        $display("FAIL gap_y cycle%0d: got %b%b want 00", i, y_ov, y_nov);
      end
      settle();
      checks++;
      if (st_ov !== 2'd3) begin
        errors++;
        $display("FAIL gap_state cycle%0d: got %0d want 3", i, st_ov);
      end
    end
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if (y_ov !== 1'b1 || y_nov !== 1'b1) begin
      errors++;
      $display("FAIL gap_final_y: got %b%b want 11", y_ov, y_nov);
    end
    settle();
    checks++;
    if (st_ov !== 2'd1 || st_nov !== 2'd0) begin
      errors++;
      $display("FAIL gap_final_state: got %0d/%0d want 1/0", st_ov, st_nov);
    end
  endtask

  task automatic test_clear();
    logic bits [4] = '{1, 1, 0, 1};
    clr_all();
    for (int i = 0; i < 4; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      settle();
    end
    for (int i = 0; i < 3; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      settle();
    end
    checks++;
    if (st_ov !== 2'd3) begin
      errors++;
      $display("FAIL clear_pre_state: got %0d want 3", st_ov);
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_ov !== 8'd1) begin
      errors++;
      $display("FAIL clear_pre_cnt: got %0d want 1", cnt_ov);
    end
`endif
    apply(1'b1, 1'b1, 1'b1);
    checks++;
    if (y_ov !== 1'b0 || y_nov !== 1'b0) begin
      errors++;
      $display("FAIL clear_y: got %b%b want 00", y_ov, y_nov);
    end
    settle();
    checks++;
    if (st_ov !== 2'd0 || st_nov !== 2'd0) begin
      errors++;
      $display("FAIL clear_state: got %0d/%0d want 0/0", st_ov, st_nov);
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_ov !== 8'd0) begin
      errors++;
      $display("FAIL clear_cnt: got %0d want 0", cnt_ov);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic bits [3] = '{1, 1, 0};
    clr_all();
    for (int i = 0; i < 3; i++) begin
      apply(bits[i], 1'b1, 1'b0);
      settle();
    end
    @(negedge clock);
    x_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (st_ov !== 2'd0 || st_nov !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_state: got %0d/%0d want 0/0", st_ov, st_nov);
    end
    @(negedge clock);
    x_in = 1'b1; x_valid = 1'b1;
    #1;
    checks++;
    if (y_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_y_in_reset: got %b want 0", y_ov);
    end
    @(negedge clock);
    reset = 1'b1;
    x_in = 1'b1; x_valid = 1'b1; clear = 1'b0;
    #1;
    checks++;
    if (y_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_y_after: got %b want 0", y_ov);
    end
    settle();
    checks++;
    if (st_ov !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_restart_state: got %0d want 1", st_ov);
    end
  endtask

  task automatic test_saturate();
    logic ey     [6] = '{0, 1, 1, 1, 1, 1};
    int   ec_pre [6] = '{0, 0, 1, 2, 3, 3};
    clr_all();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      checks++;
      if (y_11 !== ey[i]) begin
        errors++;
        $display("FAIL sat_y bit%0d: got %b want %b", i+1, y_11, ey[i]);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (int'(cnt_11) != ec_pre[i]) begin
        errors++;
        $display("FAIL sat_cnt bit%0d: got %0d want %0d", i+1, cnt_11, ec_pre[i]);
      end
`endif
      settle();
      checks++;
      if (st_11 !== 1'd1) begin
        errors++;
        $display("FAIL sat_state bit%0d: got %0d want 1", i+1, st_11);
      end
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_11 !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt_final: got %0d want 3", cnt_11);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_fallback();
    test_valid_gap();
    test_clear();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector, successor to the fixed four-state Mealy machines in the lab FSM set. It watches a 1-bit serial stream and flags, Mealy-style, the cycle in which the last bit of a configurable PAT_W-bit pattern arrives. It supports overlapping or non-overlapping detection, a per-cycle input qualifier, a synchronous clear and an optional saturating match counter. It sits between a serial input source and downstream control logic as a drop-in generalisation of the lab detectors.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = restart from empty after a match.
- CNT_W, 8, match counter width; only used with SEQDET_COUNT_EN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- x_in  input  1  serial data bit.
- x_valid  input  1  x_in is sampled only when high.
- clear  input  1  synchronous clear of state and counter; takes priority over x_valid.
- y_out  output  1  Mealy match flag, combinational.
- state_o  output  $clog2(PAT_W)  current matched-prefix length, for debug.
- match_cnt  output  CNT_W  saturating match count; present only with SEQDET_COUNT_EN.

## Operation
- state = length of the longest suffix of the accepted bits that is a proper prefix of PATTERN. Range 0..PAT_W-1.
- Accepted bits are those with x_valid = 1 since the last reset, clear or non-overlap match.
- The fallback (failure) table is computed at elaboration by a constant function over PATTERN. There is no runtime table.
- On a valid bit b in state s, define p = PATTERN[PAT_W-1-s] (the expected bit):
  - b == p and s < PAT_W-1: next = s+1.
  - b == p and s == PAT_W-1: match. next = border(PATTERN) if OVERLAP=1, else 0.
  - b != p: follow the fallback chain to the longest prefix that can be extended by b; next = that length + 1, or 0 if none.
- y_out = x_valid & ~clear & (state == PAT_W-1) & (x_in == PATTERN[0]).
- x_valid = 0: state holds, and y_out = 0.
- clear = 1: next state = 0 and the counter is cleared to 0. y_out = 0 that cycle, even if the bit would have matched.
- Counter: increments by 1 on each cycle where y_out = 1. It saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (asynchronous, reset = 0): state = 0 and match_cnt = 0 immediately. y_out = 0 while in reset.
- y_out rises in the same cycle as the final pattern bit (zero latency). The state update lands at the next rising edge.
- match_cnt reflects a match one cycle after y_out.
- Reset asserted mid-sequence: the partial match is discarded; detection restarts from state 0 after release.
- Reset deassertion is sampled synchronously by the rising edge after release; the first bit is accepted at that edge.

## Configuration
- SEQDET_COUNT_EN defined: the match_cnt port and saturating counter are compiled in.
- SEQDET_COUNT_EN undefined: no match_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Shared package seqdet_pkg holds:
  - the state-width helper;
  - the constant function computing the failure/border table from PATTERN and PAT_W;
  - default-pattern localparams used by tests.
- One sub-module, seqdet_sat_counter (parameter CNT_W; inc, clr, count). It is instantiated only under SEQDET_COUNT_EN.
- The FSM next-state logic and the Mealy output stay in seq_detect_param.

## Test plan
- PATTERN 1101, OVERLAP=1, x_valid=1, stream 1,1,0,1,1,0,1 -> y_out = 1 on bits 4 and 7 only; match_cnt = 2.
- Same stream with OVERLAP=0 -> y_out = 1 on bit 4 only; state = 0 after bit 4.
- PATTERN 1101, stream 1,1,1,0,1 -> the fallback keeps state at 2 through the repeated 1s; y_out = 1 on bit 5.
- Stream 1,1,0 then x_valid = 0 for 3 cycles with x_in toggling, then 1 -> state holds at 3; y_out = 1 only on the final valid bit.
- clear pulsed alongside the final 1 of 1101 -> y_out = 0, state = 0, match_cnt = 0. Reset pulsed after 1,1,0 -> state = 0 asynchronously; a following 1 gives y_out = 0.
- CNT_W = 2 with 5 overlapping matches of PATTERN 11 (stream of six 1s) -> match_cnt saturates at 3.
